// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared widths and pointer arithmetic for the RAM stream reader
package bram_stream_pkg;
    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 8;
    localparam int PTR_W     = ADDR_W + 1;
    localparam int RAM_DEPTH = 2 ** ADDR_W;

    localparam logic [PTR_W-1:0] FULL_LEVEL = PTR_W'(RAM_DEPTH);

    // Pointers carry one extra bit so full (diff == depth) and empty (diff == 0) differ.
    function automatic logic [PTR_W-1:0] ptr_diff(input logic [PTR_W-1:0] a,
                                                  input logic [PTR_W-1:0] b);
        return a - b;
    endfunction
endpackage

// File: rtl/bram_stream_reader_if.sv
// rtl/bram_stream_reader_if.sv - RAM read port, writer pointer and byte stream bundle
interface bram_stream_reader_if
    import bram_stream_pkg::*;
    ;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  level;
    logic [ADDR_W-1:0] dpra;
    logic [DATA_W-1:0] dpo;
    logic [DATA_W-1:0] dout;
    logic              flush;
    logic              dout_valid;
    logic              dout_ready;
    logic              empty;
    logic              overrun;

    modport slave (
        input  wr_ptr, dpo, flush, dout_ready,
        output rd_ptr, dpra, dout, dout_valid, level, empty, overrun
    );

    modport master (
        output wr_ptr, dpo, flush, dout_ready,
        input  rd_ptr, dpra, dout, dout_valid, level, empty, overrun
    );
endinterface

// File: rtl/byte_skid_buffer.sv
// rtl/byte_skid_buffer.sv - two-entry byte FIFO holding RAM read data until it is consumed
module byte_skid_buffer
    import bram_stream_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    input  logic              clear,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // The head register always holds the oldest byte so dout needs no mux.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = din;
                    else                 tail_d = din;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = din;
                    end else begin
                        head_d = tail_q;
                        tail_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = head_q;
    assign valid = (count_q != 2'd0);
    assign count = count_q;
endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - drains committed bytes from the dual-port RAM as a valid/ready stream
module bram_stream_reader
    import bram_stream_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    bram_stream_reader_if.slave  bus
);
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  fetch_q, fetch_d;
    logic              inflight_q, inflight_d;
    logic              overrun_q, overrun_d;

    logic [1:0]        buf_count;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_head;
    logic              pop, push, issue;
    logic [2:0]        occupancy;
    logic [PTR_W-1:0]  unread;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q       <= '0;
            fetch_q    <= '0;
            inflight_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            fetch_q    <= fetch_d;
            inflight_q <= inflight_d;
            overrun_q  <= overrun_d;
        end
    end

    // A read is only launched when its byte is guaranteed a buffer slot on return.
    always_comb begin
        pop       = buf_valid & bus.dout_ready & ~bus.flush;
        push      = inflight_q & ~bus.flush;
        occupancy = {1'b0, buf_count} + {2'b00, inflight_q};
        issue     = (bus.wr_ptr != fetch_q) & (occupancy < (3'd2 + {2'b00, pop})) & ~bus.flush;
        unread    = ptr_diff(bus.wr_ptr, rd_q);

        rd_d       = rd_q;
        fetch_d    = fetch_q;
        inflight_d = issue;
        overrun_d  = overrun_q | (unread > FULL_LEVEL);

        if (bus.flush) begin
            rd_d    = bus.wr_ptr;
            fetch_d = bus.wr_ptr;
        end else begin
            if (pop)   rd_d    = rd_q + 1'b1;
            if (issue) fetch_d = fetch_q + 1'b1;
        end
    end

    byte_skid_buffer u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.dpo),
        .pop   (pop),
        .clear (bus.flush),
        .dout  (buf_head),
        .valid (buf_valid),
        .count (buf_count)
    );

    assign bus.rd_ptr     = rd_q;
    assign bus.dpra       = fetch_q[ADDR_W-1:0];
    assign bus.dout       = buf_head;
    assign bus.dout_valid = buf_valid;
    assign bus.level      = unread;
    assign bus.empty      = (unread == '0);
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed and randomized checks of the stream reader against a byte-queue model
module tb_bram_stream_reader;
    import bram_stream_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bram_stream_reader_if sif();

    bram_stream_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:2047];
    always @(posedge clk) sif.dpo <= mem[sif.dpra];

    logic [7:0]  q[$];
    logic [11:0] m_rd;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs at the falling edge, score any handshake, advance to the next falling edge.
    task automatic tick(input bit we, input logic [7:0] d, input bit rdy, input bit fl);
        sif.dout_ready = rdy;
        sif.flush      = fl;
        if (sif.dout_valid && rdy && !fl) begin
            chk("pop_has_data", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                chk("stream_data", 32'(sif.dout), 32'(q[0]));
                void'(q.pop_front());
                m_rd++;
            end
        end
        if (we) begin
            mem[sif.wr_ptr[10:0]] = d;
            sif.wr_ptr = sif.wr_ptr + 12'd1;
            q.push_back(d);
        end
        if (fl) begin
            q.delete();
            m_rd = sif.wr_ptr;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    logic [10:0] window;
    logic [11:0] exp_lvl;

    initial begin
        sif.wr_ptr     = '0;
        sif.flush      = 1'b0;
        sif.dout_ready = 1'b0;
        m_rd           = '0;
        repeat (2) @(negedge clk);

        chk("rst_rd_ptr",  32'(sif.rd_ptr),     32'd0);
        chk("rst_dpra",    32'(sif.dpra),       32'd0);
        chk("rst_dout",    32'(sif.dout),       32'd0);
        chk("rst_valid",   32'(sif.dout_valid), 32'd0);
        chk("rst_overrun", 32'(sif.overrun),    32'd0);
        chk("rst_level",   32'(sif.level),      32'd0);
        chk("rst_empty",   32'(sif.empty),      32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Three back-to-back bytes: visible two edges after the first commit, then one per clock.
        tick(1'b1, 8'h41, 1'b1, 1'b0);
        chk("t1_valid_e1", 32'(sif.dout_valid), 32'd0);
        tick(1'b1, 8'h42, 1'b1, 1'b0);
        chk("t1_valid_e2", 32'(sif.dout_valid), 32'd1);
        chk("t1_byte0",    32'(sif.dout),       32'h41);
        tick(1'b1, 8'h43, 1'b1, 1'b0);
        chk("t1_byte1",    32'(sif.dout),       32'h42);
        chk("t1_valid1",   32'(sif.dout_valid), 32'd1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_byte2",    32'(sif.dout),       32'h43);
        chk("t1_valid2",   32'(sif.dout_valid), 32'd1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_valid_end", 32'(sif.dout_valid), 32'd0);
        chk("t1_rd_ptr",    32'(sif.rd_ptr),     32'd3);
        chk("t1_level",     32'(sif.level),      32'd0);
        chk("t1_empty",     32'(sif.empty),      32'd1);

        // Back-pressure: head byte held, prefetch bounded to the two buffer slots.
        for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            window = sif.dpra - sif.rd_ptr[10:0];
            chk("t2_hold_valid", 32'(sif.dout_valid), 32'd1);
            chk("t2_hold_data",  32'(sif.dout),       32'(q[0]));
            chk("t2_window",     32'(window <= 11'd2), 32'd1);
            chk("t2_level",      32'(sif.level),      32'd5);
            tick(1'b0, 8'h00, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            chk("t2_no_gap", 32'(sif.dout_valid), 32'd1);
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t2_drained", 32'(sif.dout_valid), 32'd0);
        chk("t2_rd_ptr",  32'(sif.rd_ptr),     32'(m_rd));

        // Address wrap 2047 -> 0 with the pointer MSB toggling.
        sif.wr_ptr = 12'd2046;
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_rd_ptr", 32'(sif.rd_ptr), 32'd2046);
        for (int i = 0; i < 4; i++) begin
            chk("t3_dpra", 32'(sif.dpra), 32'((2046 + i) % 2048));
            tick(1'b1, 8'($urandom), 1'b1, 1'b0);
        end
        drain(4);
        chk("t3_rd_ptr_wrap", 32'(sif.rd_ptr), 32'h802);
        chk("t3_empty",       32'(sif.empty),  32'd1);

        // Full is legal; one byte beyond full is a lap and latches overrun.
        for (int i = 0; i < 2048; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("t4_level_full",   32'(sif.level),   32'd2048);
        chk("t4_overrun_full", 32'(sif.overrun), 32'd0);
        tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("t4_overrun_lap",  32'(sif.overrun), 32'd1);
        chk("t4_level_lap",    32'(sif.level),   32'd2049);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4_overrun_sticky", 32'(sif.overrun),    32'd1);
        chk("t4_level_flushed",  32'(sif.level),      32'd0);
        chk("t4_valid_flushed",  32'(sif.dout_valid), 32'd0);

        // Flush with a full output buffer, and flush while a read is returning.
        for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_pre_valid", 32'(sif.dout_valid), 32'd1);
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        chk("t5_valid",    32'(sif.dout_valid), 32'd0);
        chk("t5_rd_ptr",   32'(sif.rd_ptr),     32'(sif.wr_ptr));
        chk("t5_dpra",     32'(sif.dpra),       32'(sif.wr_ptr[10:0]));
        chk("t5_level",    32'(sif.level),      32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            chk("t5_stay_empty", 32'(sif.dout_valid), 32'd0);
        end
        tick(1'b1, 8'($urandom), 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        chk("t5_inflight_valid", 32'(sif.dout_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            chk("t5_inflight_dropped", 32'(sif.dout_valid), 32'd0);
        end
        tick(1'b1, 8'($urandom), 1'b1, 1'b0);
        chk("t5_late_e1", 32'(sif.dout_valid), 32'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_late_e2", 32'(sif.dout_valid), 32'd1);
        drain(2);
        chk("t5_rd_ptr_end", 32'(sif.rd_ptr), 32'(m_rd));

        // Random traffic with occasional flushes, scored against the byte queue.
        for (int i = 0; i < 400; i++) begin
            exp_lvl = sif.wr_ptr - m_rd;
            tick(($urandom_range(0, 1) == 1) && (exp_lvl < 12'd2047), 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
        end
        drain(6);
        exp_lvl = sif.wr_ptr - m_rd;
        chk("rand_rd_ptr", 32'(sif.rd_ptr),     32'(m_rd));
        chk("rand_level",  32'(sif.level),      32'(exp_lvl));
        chk("rand_valid",  32'(sif.dout_valid), 32'd0);
        chk("rand_queue",  32'(q.size()),       32'd0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_pre_valid", 32'(sif.dout_valid), 32'd1);
        sif.dout_ready = 1'($urandom_range(0, 1));
        #2 reset = 1'b1;
        #1;
        chk("t6_rd_ptr",  32'(sif.rd_ptr),     32'd0);
        chk("t6_dpra",    32'(sif.dpra),       32'd0);
        chk("t6_dout",    32'(sif.dout),       32'd0);
        chk("t6_valid",   32'(sif.dout_valid), 32'd0);
        chk("t6_overrun", 32'(sif.overrun),    32'd0);
        chk("t6_level",   32'(sif.level),      32'(sif.wr_ptr));
        chk("t6_empty",   32'(sif.empty),      32'(sif.wr_ptr == 12'd0));
        sif.wr_ptr = '0;
        q.delete();
        m_rd = '0;
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1, 8'($urandom), 1'b1, 1'b0);
        chk("t6_resume_addr", 32'(sif.dpra), 32'd1);
        for (int i = 0; i < 30; i++)
            tick($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, 1'b0);
        drain(8);
        chk("t6_rd_ptr_end", 32'(sif.rd_ptr), 32'(m_rd));
        chk("t6_level_end",  32'(sif.level),  32'd0);
        chk("t6_queue_end",  32'(q.size()),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
